// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Holds the opcode, funct and alucontrol encodings, the FSM state and ALU-op
// enumerations, and small opcode classification helpers.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_t;

  // What the FSM asks of the ALU decoder in a given state.
  typedef enum logic [2:0] {
    ALUOP_NONE,   // alucontrol driven to 000
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT,  // decode from funct (R-type)
    ALUOP_IMM     // decode from opcode (immediate ops)
  } aluop_t;

  // Immediate logical ops zero-extend their immediate.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALU request plus funct/opcode to alucontrol.
// Ports:
//   aluop      - request from the controller FSM
//   op         - opcode (latched copy) used for immediate ops
//   funct      - R-type funct field
//   alucontrol - 3-bit ALU operation select
module aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = '0;
    case (aluop)
      ALUOP_NONE: alucontrol = '0;
      ALUOP_ADD:  alucontrol = ALU_ADD;
      ALUOP_SUB:  alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        case (op)
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch/decode/execute for
// lw, sw, R-type, beq, addi/andi/ori and j.
// Ports:
//   clk, reset (async active-low)
//   op, funct       - instruction fields from the IR
//   zero            - ALU zero flag (branch decision)
//   pcen, irwrite, regwrite, memwrite - write enables
//   iord, regdst, memtoreg, alusrca, sgnzero - datapath mux selects
//   alusrcb, pcsrc  - 2-bit selects
//   alucontrol      - ALU operation
//   done            - one-cycle pulse in the last state of each instruction
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       sgnzero,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       done
);

  state_t     state, state_next;
  aluop_t     aluop;
  logic [5:0] op_q;

  // Opcode captured in DECODE so later states are immune to IR changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
    end else if (state == S_DECODE) begin
      op_q <= op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:             state_next = S_MEMADR;
          OP_RTYPE:                 state_next = S_EXECUTE;
          OP_BEQ:                   state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_IMMEX;
          OP_J:                     state_next = S_JUMP;
          default:                  state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_IMMEX:   state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcen     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    sgnzero  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    done     = 1'b0;
    aluop    = ALUOP_NONE;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluop   = ALUOP_ADD;
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALUOP_ADD;
        // Unrecognised opcodes end here as a NOP.
        done    = !op_known(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        done     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = zero;
        done    = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_IMM;
        sgnzero = is_zero_ext(op_q);
      end
      S_IMMWB: begin
        aluop    = ALUOP_IMM;
        sgnzero  = is_zero_ext(op_q);
        regwrite = 1'b1;
        done     = 1'b1;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH during reset; only the enables need masking.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      done     = 1'b0;
    end
  end

  aludec u_aludec (
    .aluop      (aluop),
    .op         (op_q),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Output signature bit order:
//   {pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca,
//    sgnzero, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], done}
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite;
  logic       iord, regdst, memtoreg, alusrca, sgnzero;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       done;
  logic [16:0] sig;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .sgnzero    (sgnzero),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .done       (done)
  );

  assign sig = {pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
                alusrca, sgnzero, alusrcb, pcsrc, alucontrol, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived expected signatures for each state
  localparam logic [16:0] X_RST     = {4'b0000, 5'b00000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_FETCH   = {4'b1100, 5'b00000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_DEC     = {4'b0000, 5'b00000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_DECNOP  = {4'b0000, 5'b00000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [16:0] X_MEMADR  = {4'b0000, 5'b00010, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_MEMRD   = {4'b0000, 5'b10000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] X_MEMWB   = {4'b0010, 5'b00100, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [16:0] X_MEMWR   = {4'b0001, 5'b10000, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [16:0] X_EXSLT   = {4'b0000, 5'b00010, 2'b00, 2'b00, 3'b111, 1'b0};
  localparam logic [16:0] X_EXADD   = {4'b0000, 5'b00010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_ALUWB   = {4'b0010, 5'b01000, 2'b00, 2'b00, 3'b000, 1'b1};
  localparam logic [16:0] X_BR1     = {4'b1000, 5'b00010, 2'b00, 2'b01, 3'b110, 1'b1};
  localparam logic [16:0] X_BR0     = {4'b0000, 5'b00010, 2'b00, 2'b01, 3'b110, 1'b1};
  localparam logic [16:0] X_IMEXOR  = {4'b0000, 5'b00011, 2'b10, 2'b00, 3'b001, 1'b0};
  localparam logic [16:0] X_IMWBOR  = {4'b0010, 5'b00001, 2'b00, 2'b00, 3'b001, 1'b1};
  localparam logic [16:0] X_IMEXADD = {4'b0000, 5'b00010, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] X_IMWBADD = {4'b0010, 5'b00000, 2'b00, 2'b00, 3'b010, 1'b1};
  localparam logic [16:0] X_JUMP    = {4'b1000, 5'b00000, 2'b00, 2'b10, 3'b000, 1'b1};

  task automatic test_reset();
    reset = 1'b0;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    #12;
    checks++;
    if (sig !== X_RST) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", sig, X_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (sig !== X_FETCH) begin
      errors++;
      $display("FAIL reset_release_fetch: got %b expected %b", sig, X_FETCH);
    end
  endtask

  // lw: 5 cycles; op scrambled after DECODE must not alter sequencing
  task automatic test_lw();
    logic [16:0] exp [6];
    exp = '{X_FETCH, X_DEC, X_MEMADR, X_MEMRD, X_MEMWB, X_FETCH};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) op = 6'b101011;
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL lw step %0d: got %b expected %b", i, sig, exp[i]);
      end
      if (i != 5) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp [5];
    exp = '{X_FETCH, X_DEC, X_MEMADR, X_MEMWR, X_FETCH};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) op = 6'b100011;
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL sw step %0d: got %b expected %b", i, sig, exp[i]);
      end
      if (i != 4) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [16:0] ex_sig);
    logic [16:0] exp [5];
    exp = '{X_FETCH, X_DEC, ex_sig, X_ALUWB, X_FETCH};
    op    = 6'b000000;
    funct = fn;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL rtype_%b step %0d: got %b expected %b", fn, i, sig, exp[i]);
      end
      if (i != 4) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_beq(input logic z, input logic [16:0] br_sig);
    logic [16:0] exp [4];
    exp = '{X_FETCH, X_DEC, br_sig, X_FETCH};
    op   = 6'b000100;
    zero = z;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL beq_zero%0d step %0d: got %b expected %b", z, i, sig, exp[i]);
      end
      if (i != 3) begin
        @(posedge clk);
        #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic [16:0] ex_sig,
                          input logic [16:0] wb_sig);
    logic [16:0] exp [5];
    exp = '{X_FETCH, X_DEC, ex_sig, X_IMMWB_GUARD(wb_sig), X_FETCH};
    op = opc;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) op = 6'b000000;
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL imm_%b step %0d: got %b expected %b", opc, i, sig, exp[i]);
      end
      if (i != 4) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic logic [16:0] X_IMMWB_GUARD(input logic [16:0] s);
    return s;
  endfunction

  task automatic test_nop();
    logic [16:0] exp [3];
    exp = '{X_FETCH, X_DECNOP, X_FETCH};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL nop step %0d: got %b expected %b", i, sig, exp[i]);
      end
      if (i != 2) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_jump();
    logic [16:0] exp [4];
    exp = '{X_FETCH, X_DEC, X_JUMP, X_FETCH};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL jump step %0d: got %b expected %b", i, sig, exp[i]);
      end
      if (i != 3) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Reset pulsed during MEMRD of lw: abandon, then restart at FETCH
  task automatic test_reset_mid();
    logic [16:0] exp [4];
    exp = '{X_FETCH, X_DEC, X_MEMADR, X_MEMRD};
    op = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sig !== exp[i]) begin
        errors++;
        $display("FAIL reset_mid_pre step %0d: got %b expected %b", i, sig, exp[i]);
      end
      if (i != 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sig !== X_RST) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", sig, X_RST);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sig !== X_RST) begin
      errors++;
      $display("FAIL reset_mid_held: got %b expected %b", sig, X_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (sig !== X_FETCH) begin
      errors++;
      $display("FAIL reset_mid_release: got %b expected %b", sig, X_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype(6'b101010, X_EXSLT);
    test_rtype(6'b111111, X_EXADD);
    test_beq(1'b1, X_BR1);
    test_beq(1'b0, X_BR0);
    test_imm(6'b001101, X_IMEXOR, X_IMWBOR);
    test_imm(6'b001000, X_IMEXADD, X_IMWBADD);
    test_nop();
    test_jump();
    test_reset_mid();
    test_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Interface: clk  input  1  single clock; all state updates on rising edge.
REQ-002 Interface: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 Interface: op  input  6  instr[31:26] from instruction register.
REQ-004 Interface: funct  input  6  instr[5:0] from instruction register.
REQ-005 Interface: zero  input  1  ALU zero flag from datapath.
REQ-006 Interface: pcen / irwrite / regwrite / memwrite  output  1 each  write enables to PC, IR, register file, memory.
REQ-007 Interface: iord / regdst / memtoreg / alusrca / sgnzero  output  1 each  mux selects to datapath.
REQ-008 Interface: alusrcb / pcsrc  output  2 each  ALU B select (00 reg, 01 const 4, 10 imm, 11 imm<<2); PC select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 Interface: alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 Interface: done  output  1  one-cycle pulse in the last state of each instruction.

Function
REQ-011 Controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, JUMP.
REQ-012 FETCH SHALL assert iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1; next DECODE.
REQ-013 DECODE SHALL assert alusrca=0, alusrcb=11, alucontrol=010 (branch target precompute); next state by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000/001100/001101 -> IMMEX, 000010 -> JUMP.
REQ-014 Unrecognised op in DECODE SHALL return to FETCH with done=1 and no write enable asserted (treated as NOP).
REQ-015 MEMADR: alusrca=1, alusrcb=10, sgnzero=0, add; next MEMRD if op=100011, MEMWR if op=101011.
REQ-016 MEMRD: iord=1; next MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1, done=1; next FETCH.
REQ-017 MEMWR: iord=1, memwrite=1, done=1; next FETCH.
REQ-018 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other -> add); next ALUWB.
REQ-019 ALUWB: regdst=1, memtoreg=0, regwrite=1, done=1; next FETCH.
REQ-020 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero, done=1; next FETCH.
REQ-021 IMMEX: alusrca=1, alusrcb=10; addi -> add with sgnzero=0; andi -> and, ori -> or, both sgnzero=1 (zero-extend); next IMMWB.
REQ-022 IMMWB: regdst=0, memtoreg=0, regwrite=1, done=1, alucontrol/sgnzero held as IMMEX; next FETCH.
REQ-023 JUMP: pcsrc=10, pcen=1, done=1; next FETCH.
REQ-024 Outputs not listed for a state SHALL be 0 (selects) / 0 (enables).
REQ-025 Latency SHALL be: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3 cycles, FETCH inclusive.
REQ-026 op/funct SHALL be sampled only in DECODE/EXECUTE/IMMEX; changes in other states have no effect on sequencing.

Reset
REQ-027 reset=0 SHALL force state to FETCH immediately, independent of clk.
REQ-028 While reset=0, pcen, irwrite, regwrite, memwrite, done SHALL be 0; selects take FETCH values.
REQ-029 Reset asserted mid-instruction SHALL abandon it; first rising edge after release executes FETCH.

Structure
REQ-030 Opcode, funct, alucontrol and state encodings SHALL live in shared package mips_pkg.
REQ-031 ALU decoding (aluop + funct/op -> alucontrol) SHALL be sub-module aludec; FSM and output decode stay in multicycle_ctrl.

Verification
REQ-032 Release reset, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1,memtoreg=1 only in cycle 5; done pulses cycle 5.
REQ-033 op=000000, funct=101010 -> alucontrol=111 in EXECUTE, regwrite=1,regdst=1 in ALUWB.
REQ-034 op=000100 with zero=1 -> pcen=1,pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0.
REQ-035 op=001101 -> alucontrol=001, sgnzero=1 in IMMEX and IMMWB; regwrite=1 in IMMWB only.
REQ-036 op=111111 -> DECODE returns to FETCH, done=1, no write enable asserted throughout.
REQ-037 reset pulsed low during MEMRD of lw -> all enables 0 immediately, no regwrite, next instruction starts at FETCH.
